// File: rtl/nios_system_onchip_ram_pipelined.sv
// Single-port on-chip RAM, Avalon-MM slave, with pipelined reads (readdatavalid)
// and a post-reset clear FSM that zeroes (or fills) the array before accepting commands.
// Optional feature macro: NIOS_ONCHIP_RAM_OUTREG_EN adds an output register stage
// (read latency 2 instead of 1, throughput unchanged).
module nios_system_onchip_ram_pipelined #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 4096,
  parameter int INIT_CLEAR = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clken,
  input  logic                    reset_req,
  input  logic                    chipselect,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic [DATA_WIDTH-1:0]   writedata,
  output logic                    waitrequest,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
  output logic                    init_done
);
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef NIOS_ONCHIP_RAM_OUTREG_EN
  localparam int STAGES = 2;
`else
  localparam int STAGES = 1;
`endif

  typedef enum logic {CLEAR, READY} state_e;
  localparam state_e RST_STATE = (INIT_CLEAR != 0) ? CLEAR : READY;

  state_e                              state_q, state_d;
  logic [ADDR_WIDTH-1:0]               clr_addr_q, clr_addr_d;
  logic                                init_done_q, init_done_d;
  logic [STAGES-1:0]                   vld_q, vld_d;
  logic [STAGES-1:0][DATA_WIDTH-1:0]   dat_q, dat_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  en, acc, in_rng, wr_acc, rd_acc, clr_we, clr_last;
  logic [DATA_WIDTH-1:0] rd_word;

  // Command decode and clear-FSM next state
  always_comb begin
    en          = clken & ~reset_req;
    waitrequest = reset | (state_q != READY) | ~en;
    acc         = chipselect & ~waitrequest & (read | write);
    in_rng      = {1'b0, address} < (ADDR_WIDTH+1)'(DEPTH);
    wr_acc      = acc & write & in_rng;
    rd_acc      = acc & read & ~write;
    clr_we      = en & ~reset & (state_q == CLEAR);
    clr_last    = clr_addr_q == ADDR_WIDTH'(DEPTH - 1);
    rd_word     = in_rng ? mem[address[IDX_W-1:0]] : '0;

    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    init_done_d = init_done_q;
    if (en) begin
      case (state_q)
        CLEAR: begin
          if (clr_last) begin
            state_d     = READY;
            init_done_d = 1'b1;
          end else begin
            clr_addr_d  = clr_addr_q + 1'b1;
          end
        end
        READY:   init_done_d = 1'b1;
        default: state_d     = RST_STATE;
      endcase
    end
  end

  // Read pipeline: stage 0 samples the array, later stages shift forward; data holds when idle
  always_comb begin
    vld_d    = vld_q;
    dat_d    = dat_q;
    vld_d[0] = rd_acc;
    if (rd_acc) dat_d[0] = rd_word;
    for (int i = 1; i < STAGES; i++) begin
      vld_d[i] = vld_q[i-1];
      if (vld_q[i-1]) dat_d[i] = dat_q[i-1];
    end
  end

  // State, counter and pipeline registers; everything freezes when en=0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RST_STATE;
      clr_addr_q  <= '0;
      init_done_q <= 1'b0;
      vld_q       <= '0;
      dat_q       <= '0;
    end else if (en) begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      init_done_q <= init_done_d;
      vld_q       <= vld_d;
      dat_q       <= dat_d;
    end
  end

  // Array writes: clear sweep has priority (commands are blocked while clearing)
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr_q[IDX_W-1:0]] <= CLEAR_VALUE;
    end else if (wr_acc) begin
      for (int b = 0; b < BE_W; b++)
        if (byteenable[b]) mem[address[IDX_W-1:0]][b*8 +: 8] <= writedata[b*8 +: 8];
    end
  end

  assign readdata      = dat_q[STAGES-1];
  assign readdatavalid = vld_q[STAGES-1];
  assign init_done     = init_done_q;

endmodule

// File: tb/tb_nios_system_onchip_ram_pipelined.sv
// Directed + randomized bench for nios_system_onchip_ram_pipelined (DEPTH=16, ADDR_WIDTH=5).
// The reference keeps a word array, a clear countdown and a queue of pending reads,
// each tagged with the en-cycle on which its data is due.
module tb_nios_system_onchip_ram_pipelined;
  localparam int DW = 32, AW = 5, DEPTH = 16, BE_W = 4;
  localparam logic [31:0] CV = 32'hA5A5A5A5;
`ifdef NIOS_ONCHIP_RAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0, clken = 1'b1, reset_req = 1'b0;
  logic chipselect = 1'b0, read = 1'b0, write = 1'b0;
  logic [AW-1:0]   address = '0;
  logic [BE_W-1:0] byteenable = '0;
  logic [DW-1:0]   writedata = '0;
  logic            waitrequest, readdatavalid, init_done;
  logic [DW-1:0]   readdata;

  nios_system_onchip_ram_pipelined #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .INIT_CLEAR(1), .CLEAR_VALUE(CV)
  ) dut (
    .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
    .chipselect(chipselect), .address(address), .read(read), .write(write),
    .byteenable(byteenable), .writedata(writedata), .waitrequest(waitrequest),
    .readdata(readdata), .readdatavalid(readdatavalid), .init_done(init_done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] d; int due; } rd_t;
  logic [31:0] mdl [DEPTH];
  rd_t         pq[$];
  int          clr_left, en_cnt, rdv_seen;
  logic        exp_rdv;
  logic [31:0] exp_rd;
  int          n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic do_reset(input int hold);
    reset = 1'b1; chipselect = 0; read = 0; write = 0; clken = 1; reset_req = 0;
    #1;
    chk("rst_rdv", 32'(readdatavalid), 0);
    chk("rst_readdata", readdata, 0);
    chk("rst_waitreq", 32'(waitrequest), 1);
    chk("rst_init_done", 32'(init_done), 0);
    repeat (hold) @(posedge clk);
    #1 reset = 1'b0;
    clr_left = DEPTH; pq.delete(); exp_rdv = 0; exp_rd = 0;
    for (int i = 0; i < DEPTH; i++) mdl[i] = CV;
  endtask

  task automatic step(input logic cs, input logic rd, input logic wr, input logic [AW-1:0] a,
                      input logic [3:0] be, input logic [31:0] wd, input logic ce, input logic rq);
    logic en, wr_exp, acc;
    chipselect = cs; read = rd; write = wr; address = a; byteenable = be;
    writedata = wd; clken = ce; reset_req = rq;
    #1;
    en     = ce & ~rq;
    wr_exp = (clr_left != 0) | ~en;
    chk("waitrequest", 32'(waitrequest), 32'(wr_exp));
    acc = cs & ~wr_exp & (rd | wr);
    @(posedge clk); #1;
    if (en) begin
      if (clr_left > 0) clr_left--;
      en_cnt++;
      if (acc && rd && !wr)
        pq.push_back('{d: (a < DEPTH) ? mdl[a[3:0]] : 32'h0, due: en_cnt + LAT - 1});
      if (acc && wr && a < DEPTH)
        for (int b = 0; b < BE_W; b++) if (be[b]) mdl[a[3:0]][b*8 +: 8] = wd[b*8 +: 8];
      exp_rdv = 1'b0;
      if (pq.size() > 0 && pq[0].due == en_cnt) begin
        exp_rdv = 1'b1; exp_rd = pq[0].d; void'(pq.pop_front());
      end
      if (readdatavalid) rdv_seen++;
    end
    chk("readdatavalid", 32'(readdatavalid), 32'(exp_rdv));
    chk("readdata", readdata, exp_rd);
    chk("init_done", 32'(init_done), 32'(clr_left == 0));
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, '0, '0, '0, 1, 0);
  endtask

  task automatic rd_cmd(input logic [AW-1:0] a);
    step(1, 1, 0, a, '0, '0, 1, 0);
  endtask

  task automatic wr_cmd(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
    step(1, 0, 1, a, be, d, 1, 0);
  endtask

  initial begin
    int base;
    en_cnt = 0; rdv_seen = 0;
    #2;
    // Reset and full clear: waitrequest high exactly DEPTH en-cycles
    do_reset(2);
    idle(DEPTH);
    chk("ready_after_clear", 32'(init_done), 1);
    // Every word holds the clear value
    for (int i = 0; i < DEPTH; i++) rd_cmd(AW'(i));
    idle(LAT + 1);

    // Byte-enable merge
    wr_cmd(5, 32'h11223344, 4'b1111);
    wr_cmd(5, 32'hAABBCCDD, 4'b0101);
    rd_cmd(5);
    if (LAT == 2) idle(1);
    chk("be_merge_valid", 32'(readdatavalid), 1);
    chk("be_merge_data", readdata, 32'h11BB33DD);
    idle(LAT + 1);

    // Gapless burst, then the same burst with a 3-cycle clken stall in the middle
    for (int i = 0; i < 8; i++) wr_cmd(AW'(i), 32'hC0DE0000 + i, 4'hF);
    base = rdv_seen;
    for (int i = 0; i < 8; i++) rd_cmd(AW'(i));
    idle(LAT + 1);
    chk("burst_pulses", rdv_seen - base, 8);
    base = rdv_seen;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) repeat (3) step(1, 1, 0, AW'(i), '0, '0, 0, 0);
      rd_cmd(AW'(i));
    end
    idle(LAT + 1);
    chk("stall_burst_pulses", rdv_seen - base, 8);

    // Boundaries: last word, and an out-of-range write that must not alias
    wr_cmd(DEPTH - 1, 32'hDEADBEEF, 4'hF);
    rd_cmd(DEPTH - 1);
    wr_cmd(DEPTH, 32'h12345678, 4'hF);
    rd_cmd(DEPTH);
    rd_cmd(0);
    rd_cmd(DEPTH - 1);
    idle(LAT + 1);

    // read+write together, then write-then-read to the same word
    step(1, 1, 1, 3, 4'hF, 32'h7, 1, 0);
    idle(LAT + 1);
    rd_cmd(3);
    wr_cmd(4, 32'h0BADF00D, 4'hF);
    rd_cmd(4);
    wr_cmd(6, 32'h0, 4'h0);
    rd_cmd(6);
    idle(LAT + 1);

    // Randomized traffic, including out-of-range addresses and en gaps
    for (int k = 0; k < 400; k++)
      step($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), AW'($urandom_range(0, 19)),
           4'($urandom), $urandom, $urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0);
    // Reads in flight are cancelled by reset
    rd_cmd(1);
    rd_cmd(2);
    do_reset(1);

    // Reset mid-clear: 9 clear cycles (with a stall), then reset, then a full clear
    idle(4);
    step(0, 0, 0, '0, '0, '0, 1, 1);
    idle(5);
    do_reset(1);
    idle(DEPTH);
    for (int i = 0; i < DEPTH; i++) rd_cmd(AW'(i));
    idle(LAT + 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
